// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined floating-point add/subtract on {sign, exp, mant} words.
// Define FP_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module fp_addsub_pipe #(
  parameter int EXP_W  = 3,
  parameter int MANT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  funct,
  input  logic [EXP_W+MANT_W:0] a,
  input  logic [EXP_W+MANT_W:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MANT_W:0] y,
  output logic                  flag_zero,
  output logic                  flag_ovf,
  output logic                  flag_unf
);
  localparam int W   = 1 + EXP_W + MANT_W;
  localparam int XW  = EXP_W + $clog2(MANT_W + 4) + 2;
  localparam int LZW = $clog2(MANT_W + 5);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  logic advance;
  logic s1Valid_q, s2Valid_q, s3Valid_q;

  assign advance   = !s3Valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = s3Valid_q;

  // Stage 1: order operands by magnitude and align the smaller one with G/R/sticky.
  logic                     bSignEff, aZero, bZero, swap, lZero, sZero;
  logic [EXP_W+MANT_W-1:0]  magA, magB;
  logic [EXP_W-1:0]         sExp, shAmt;
  logic [MANT_W-1:0]        lMant, sMant;
  logic [MANT_W:0]          sSig;
  logic [MANT_W+2:0]        sExt, sShifted, lowMask;
  logic                     sticky;
  logic                     s1Sign_d, s1Sub_d;
  logic [EXP_W-1:0]         s1Exp_d;
  logic [MANT_W:0]          s1LSig_d;
  logic [MANT_W+3:0]        s1SSig_d;

  always_comb begin
    bSignEff = b[W-1] ^ funct;
    aZero    = (a[W-2:MANT_W] == '0);
    bZero    = (b[W-2:MANT_W] == '0);
    magA     = aZero ? '0 : a[W-2:0];
    magB     = bZero ? '0 : b[W-2:0];
    swap     = (magB > magA);
    s1Sign_d = swap ? bSignEff : a[W-1];
    s1Sub_d  = a[W-1] ^ bSignEff;
    s1Exp_d  = swap ? b[W-2:MANT_W] : a[W-2:MANT_W];
    sExp     = swap ? a[W-2:MANT_W] : b[W-2:MANT_W];
    lMant    = swap ? b[MANT_W-1:0] : a[MANT_W-1:0];
    sMant    = swap ? a[MANT_W-1:0] : b[MANT_W-1:0];
    lZero    = swap ? bZero : aZero;
    sZero    = swap ? aZero : bZero;
    s1LSig_d = lZero ? '0 : {1'b1, lMant};
    sSig     = sZero ? '0 : {1'b1, sMant};
    shAmt    = s1Exp_d - sExp;
    sExt     = {sSig, 2'b00};
    sShifted = '0;
    lowMask  = '0;
    sticky   = |sExt;
    if (int'(shAmt) < MANT_W + 3) begin
      lowMask  = ~({(MANT_W+3){1'b1}} << shAmt);
      sShifted = sExt >> shAmt;
      sticky   = |(sExt & lowMask);
    end
    s1SSig_d = {sShifted, sticky};
  end

  logic              s1Sign_q, s1Sub_q;
  logic [EXP_W-1:0]  s1Exp_q;
  logic [MANT_W:0]   s1LSig_q;
  logic [MANT_W+3:0] s1SSig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Sign_q  <= 1'b0;
      s1Sub_q   <= 1'b0;
      s1Exp_q   <= '0;
      s1LSig_q  <= '0;
      s1SSig_q  <= '0;
    end else if (advance) begin
      s1Valid_q <= in_valid;
      s1Sign_q  <= s1Sign_d;
      s1Sub_q   <= s1Sub_d;
      s1Exp_q   <= s1Exp_d;
      s1LSig_q  <= s1LSig_d;
      s1SSig_q  <= s1SSig_d;
    end
  end

  // Stage 2: L >= S in magnitude, so the difference never goes negative.
  logic [MANT_W+4:0] lFull, sFull, s2Sum_d;

  always_comb begin
    lFull   = {1'b0, s1LSig_q, 3'b000};
    sFull   = {1'b0, s1SSig_q};
    s2Sum_d = s1Sub_q ? (lFull - sFull) : (lFull + sFull);
  end

  logic              s2Sign_q;
  logic [EXP_W-1:0]  s2Exp_q;
  logic [MANT_W+4:0] s2Sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      s2Sign_q  <= 1'b0;
      s2Exp_q   <= '0;
      s2Sum_q   <= '0;
    end else if (advance) begin
      s2Valid_q <= s1Valid_q;
      s2Sign_q  <= s1Sign_q;
      s2Exp_q   <= s1Exp_q;
      s2Sum_q   <= s2Sum_d;
    end
  end

  // Stage 3: normalise, round, then saturate or flush on exponent range.
  logic [LZW-1:0]        lzc;
  logic [MANT_W+3:0]     norm;
  logic signed [XW-1:0]  expBase, expN, expR;
  logic [MANT_W-1:0]     mantOut;
  logic [W-1:0]          y_d;
  logic                  zero_d, ovf_d, unf_d;
`ifdef FP_ROUND_NEAREST_EN
  logic                  roundUp;
  logic [MANT_W+1:0]     rounded;
`endif

  always_comb begin
    lzc = '0;
    for (int i = 0; i <= MANT_W + 3; i++)
      if (s2Sum_q[i]) lzc = LZW'(MANT_W + 3 - i);
    expBase = $signed(XW'(s2Exp_q));
    if (s2Sum_q[MANT_W+4]) begin
      norm = {s2Sum_q[MANT_W+4:2], s2Sum_q[1] | s2Sum_q[0]};
      expN = expBase + EXP_ONE;
    end else begin
      norm = s2Sum_q[MANT_W+3:0] << lzc;
      expN = expBase - $signed(XW'(lzc));
    end
`ifdef FP_ROUND_NEAREST_EN
    roundUp = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded = {1'b0, norm[MANT_W+3:3]} + (MANT_W+2)'(roundUp);
    if (rounded[MANT_W+1]) begin
      mantOut = rounded[MANT_W:1];
      expR    = expN + EXP_ONE;
    end else begin
      mantOut = rounded[MANT_W-1:0];
      expR    = expN;
    end
`else
    mantOut = norm[MANT_W+2:3];
    expR    = expN;
`endif
    y_d    = '0;
    zero_d = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    if (s2Sum_q == '0) begin
      zero_d = 1'b1;
    end else if (expR > EXP_MAX) begin
      y_d   = {s2Sign_q, {(W-1){1'b1}}};
      ovf_d = 1'b1;
    end else if (expR <= EXP_ZERO) begin
      zero_d = 1'b1;
      unf_d  = 1'b1;
    end else begin
      y_d = {s2Sign_q, expR[EXP_W-1:0], mantOut};
    end
  end

`ifndef FP_ROUND_NEAREST_EN
  logic unusedGrs;
  assign unusedGrs = ^norm[2:0];
`endif

  logic [W-1:0] y_q;
  logic         zero_q, ovf_q, unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3Valid_q <= 1'b0;
      y_q       <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else if (advance) begin
      s3Valid_q <= s2Valid_q;
      y_q       <= y_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign y         = y_q;
  assign flag_zero = zero_q;
  assign flag_ovf  = ovf_q;
  assign flag_unf  = unf_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed and randomized checks of fp_addsub_pipe against an
// exact integer-arithmetic reference model of the number format.
`timescale 1ns/1ps
module tb_fp_addsub_pipe;
  localparam int EXP_W  = 3;
  localparam int MANT_W = 4;
  localparam int W      = 1 + EXP_W + MANT_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, funct, out_valid, out_ready;
  logic [W-1:0] a, b, y;
  logic         flag_zero, flag_ovf, flag_unf;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [W+2:0] expQ[$];
  logic [W-1:0] sA[4], sB[4];
  logic         sF[4];
  logic [W+2:0] sExp[4];
  int           got;

  fp_addsub_pipe #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .funct(funct),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flag_zero(flag_zero), .flag_ovf(flag_ovf), .flag_unf(flag_unf)
  );

  always #5 clk = ~clk;

  // Operand value in units of 2^(1-bias-MANT_W), so every representable value is an integer.
  function automatic int valueOf(input logic [W-1:0] x);
    int e, mag;
    e = int'(x[W-2:MANT_W]);
    if (e == 0) return 0;
    mag = ((1 << MANT_W) + int'(x[MANT_W-1:0])) << (e - 1);
    return x[W-1] ? -mag : mag;
  endfunction

  // Returns {y, zero, ovf, unf} for the exact sum rounded per the build's rounding mode.
  function automatic logic [W+2:0] refModel(input logic [W-1:0] opA, input logic [W-1:0] opB,
                                            input logic sub);
    int r, m, p, sh, q, field;
`ifdef FP_ROUND_NEAREST_EN
    int rem, half;
`endif
    logic sgn;
    r = valueOf(opA) + (sub ? -valueOf(opB) : valueOf(opB));
    if (r == 0) return {{W{1'b0}}, 3'b100};
    sgn = (r < 0);
    m   = sgn ? -r : r;
    p   = 0;
    while ((m >> (p + 1)) != 0) p++;
    field = p + 1 - MANT_W;
    sh    = p - MANT_W;
    q     = (sh > 0) ? (m >> sh) : (m << (-sh));
`ifdef FP_ROUND_NEAREST_EN
    if (sh > 0) begin
      rem  = m - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q & 1) == 1)) q++;
    end
`endif
    if (q == (1 << (MANT_W + 1))) begin
      q = q >> 1;
      field++;
    end
    if (field > (1 << EXP_W) - 1) return {sgn, {(W-1){1'b1}}, 3'b010};
    if (field <= 0) return {{W{1'b0}}, 3'b101};
    return {sgn, EXP_W'(field), MANT_W'(q), 3'b000};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] opA, input logic [W-1:0] opB,
                               input logic f, input logic rdy);
    @(negedge clk);
    in_valid  = v;
    a         = opA;
    b         = opB;
    funct     = f;
    out_ready = rdy;
  endtask

  // One isolated operation: checks the 3-edge latency and the packed result.
  task automatic directedOp(input string tag, input logic [W-1:0] opA, input logic [W-1:0] opB,
                            input logic f, input logic [W+2:0] expected);
    applyStimulus(1'b1, opA, opB, f, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_early"}, 32'(out_valid), 32'(0));
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(1));
    checkOutput({tag, "_result"}, 32'({y, flag_zero, flag_ovf, flag_unf}), 32'(expected));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; funct = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 32'(out_valid), 32'(0));
    checkOutput("reset_result", 32'({y, flag_zero, flag_ovf, flag_unf}), 32'(0));
    rst = 1'b0;
    #1 checkOutput("reset_ready", 32'(in_ready), 32'(1));

    directedOp("add_basic", 8'h30, 8'h38, 1'b0, {8'h44, 3'b000});
    directedOp("sub_equal", 8'h38, 8'h38, 1'b1, {8'h00, 3'b100});
    directedOp("overflow",  8'h7F, 8'h7F, 1'b0, {8'h7F, 3'b010});
    directedOp("underflow", 8'h11, 8'h10, 1'b1, {8'h00, 3'b101});
`ifdef FP_ROUND_NEAREST_EN
    directedOp("round_tie", 8'h30, 8'h23, 1'b0, {8'h3A, 3'b000});
`else
    directedOp("round_tie", 8'h30, 8'h23, 1'b0, {8'h39, 3'b000});
`endif

    // Backpressure: four ops with the sink stalled, then released.
    sA = '{8'h30, 8'h38, 8'h40, 8'hB0};
    sB = '{8'h38, 8'h30, 8'h40, 8'h30};
    sF = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) sExp[i] = refModel(sA[i], sB[i], sF[i]);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, sA[i], sB[i], sF[i], 1'b0);
      #1 checkOutput($sformatf("stream_ready%0d", i), 32'(in_ready), 32'(i < 3));
      if (i < 3) @(posedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("stall_valid", 32'(out_valid), 32'(1));
    checkOutput("stall_hold", 32'({y, flag_zero, flag_ovf, flag_unf}), 32'(sExp[0]));
    checkOutput("stall_ready", 32'(in_ready), 32'(0));
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (out_valid) begin
        if (got < 4)
          checkOutput($sformatf("stream_out%0d", got),
                      32'({y, flag_zero, flag_ovf, flag_unf}), 32'(sExp[got]));
        got++;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
    checkOutput("stream_count", 32'(got), 32'(4));

    // Reset with the pipeline full: nothing in flight may surface afterwards.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    #1 checkOutput("midreset_pre_valid", 32'(out_valid), 32'(1));
    rst = 1'b1;
    in_valid = 1'b0;
    #1 checkOutput("midreset_async", 32'(out_valid), 32'(0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_edge", 32'(out_valid), 32'(0));
    rst = 1'b0;
    #1 checkOutput("midreset_ready", 32'(in_ready), 32'(1));
    got = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) got++;
    end
    checkOutput("midreset_no_stale", 32'(got), 32'(0));

    // Randomized traffic with random backpressure, scoreboarded against refModel.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = W'($urandom);
      b         = W'($urandom);
      funct     = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid && out_ready) begin
        if (expQ.size() == 0)
          checkOutput("rand_spurious", 32'(out_valid), 32'(0));
        else
          checkOutput("rand_result", 32'({y, flag_zero, flag_ovf, flag_unf}), 32'(expQ.pop_front()));
      end
      if (in_valid && in_ready) expQ.push_back(refModel(a, b, funct));
    end
    for (int c = 0; c < 20 && expQ.size() != 0; c++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      if (out_valid)
        checkOutput("drain_result", 32'({y, flag_zero, flag_ovf, flag_unf}), 32'(expQ.pop_front()));
    end
    checkOutput("drain_empty", 32'(expQ.size()), 32'(0));

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, pipelined floating-point adder/subtractor.
- Successor to the 8-bit combinational mantissa datapath.
- Accepts one operation per cycle through a valid/ready handshake with backpressure, and has a fixed 3-stage latency.
- Adds overflow saturation, underflow flush-to-zero and status flags, and is generic in exponent and mantissa width.

Parameters:
- EXP_W, 3, exponent field width; bias = 2^(EXP_W-1)-1.
- MANT_W, 4, stored mantissa (fraction) width; hidden leading 1 is implied.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair and funct valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- funct  input  1  0 = A+B, 1 = A-B.
- a  input  1+EXP_W+MANT_W  operand A, format {sign, exp, mant}.
- b  input  1+EXP_W+MANT_W  operand B, same format.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- y  output  1+EXP_W+MANT_W  result.
- flag_zero  output  1  result is zero.
- flag_ovf  output  1  result saturated on overflow.
- flag_unf  output  1  result flushed to zero on underflow.

Behaviour:
- Number format: exp == 0 encodes zero, whatever mant holds. There are no denormals. An all-ones exponent is an ordinary normal value; there is no inf/NaN.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - A transfer occurs on in_valid && in_ready.
  - All three stages shift together on advance and hold otherwise. Stage valid bits propagate, so bubbles are carried.
  - Throughput is 1 per cycle. Latency is 3 cycles from accept to out_valid when there is no stall.
  - y and the flags stay stable while out_valid && !out_ready.
- Stage 1, unpack/align:
  - effective B sign = b.sign ^ funct.
  - Compare {exp, mant} magnitudes and swap so L holds the larger operand and S the smaller.
  - Prepend the hidden 1 to nonzero operands.
  - Right-shift S by L.exp - S.exp, keeping guard, round and a sticky bit (OR of all bits shifted out).
  - Shift >= MANT_W+3 leaves only the sticky bit.
  - A zero operand passes the other operand through, with its sign adjusted by funct where applicable.
- Stage 2, add:
  - effective subtract = L.sign ^ S.sign.
  - The significand sum/difference is MANT_W+5 bits wide, including carry, G, R and S.
  - Result sign = L.sign.
  - Equal magnitudes under effective subtract give +0.
- Stage 3, normalise/round/pack:
  - On carry out: shift right 1 (the dropped bit ORs into sticky) and exp+1.
  - Otherwise: a leading-zero count drives a left shift and exp - lzc.
  - Rounding follows Optional Feature.
  - A rounding carry renormalises with exp+1.
- Boundary cases:
  - exp > 2^EXP_W-1: y = {sign, all-ones exp, all-ones mant} and flag_ovf = 1.
  - exp <= 0: y = +0, flag_unf = 1 and flag_zero = 1.
  - Exact zero: y = +0 and flag_zero = 1.
- Reset: all stage valid bits, out_valid, y and flags are 0. in_ready = 1 immediately after reset. Reset mid-operation discards all in-flight results, and no partial result emerges.

Optional Feature:
- FP_ROUND_NEAREST_EN defined: round to nearest, ties to even, using G/R/S.
- Undefined: truncate (round toward zero); G/R/S are discarded and the rounding logic is removed.
- Overflow and underflow rules are identical in both builds.

Test Plan:
- Defaults, a=0x30 (1.0), b=0x38 (1.5), funct=0 -> y=0x44 (2.5) after 3 cycles, all flags 0.
- a=0x38, b=0x38, funct=1 -> y=0x00, flag_zero=1.
- a=0x7F, b=0x7F, funct=0 -> y=0x7F, flag_ovf=1.
- a=0x11, b=0x10, funct=1 -> y=0x00, flag_unf=1, flag_zero=1.
- a=0x30, b=0x23, funct=0 -> y=0x3A with FP_ROUND_NEAREST_EN; y=0x39 without it.
- Stream 4 ops back-to-back with out_ready=0:
  - in_ready drops after the 3rd accept.
  - Release out_ready -> all 4 results are delivered in order, with no loss or duplication.
  - Assert rst mid-stream -> out_valid=0 next edge, and no stale result appears after release.
